// File: rtl/day1_line_tx.sv
// Record-to-ASCII line serializer: value -> decimal digits + '\n', blank -> '\n'; first byte VAL_W+2 cycles after accept.
// One record at a time; in_ready only in IDLE, each output byte holds until out_ready takes it.
`timescale 1ns/1ps
module day1_line_tx #(
  parameter int VAL_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic             in_blank,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             busy
);

  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CAT_W = 4 * DIGITS + VAL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_FIND,
    S_EMIT,
    S_NL
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [VAL_W-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic [PTR_W-1:0]    r_ptr;
  logic [4*DIGITS-1:0] w_bcd_adj;
  logic [CAT_W-1:0]    w_cat;
  logic [PTR_W-1:0]    w_msd;
  logic [3:0]          w_digit;

  // Double-dabble step: correct each nibble, then shift value bits into the BCD side.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_cat = {w_bcd_adj, r_bin} << 1;
  end

  always_comb begin
    w_msd   = '0;
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = PTR_W'(i);
      if (PTR_W'(i) == r_ptr) w_digit = r_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_byte    = 8'h00;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = in_blank ? S_NL : S_CONVERT;
      end
      S_CONVERT: begin
        if (r_cnt == CNT_W'(VAL_W - 1)) w_state_nxt = S_FIND;
      end
      S_FIND: w_state_nxt = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        out_byte  = 8'h30 + {4'h0, w_digit};
        if (out_ready && r_ptr == '0) w_state_nxt = S_NL;
      end
      S_NL: begin
        out_valid = 1'b1;
        out_byte  = 8'h0A;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !in_blank) begin
            r_bin <= in_value;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        S_CONVERT: begin
          r_bcd <= w_cat[CAT_W-1:VAL_W];
          r_bin <= w_cat[VAL_W-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIND: r_ptr <= w_msd;
        S_EMIT: begin
          if (out_ready && r_ptr != '0) r_ptr <= r_ptr - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_day1_line_tx.sv
// Randomized self-checking bench for day1_line_tx against a divide-by-ten line model.
`timescale 1ns/1ps
module tb_day1_line_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        in_blank;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] act_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  day1_line_tx #(.VAL_W(32), .DIGITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_blank(in_blank),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .busy(busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Expected text of one record, built by repeated division by ten.
  task automatic model_line(input logic [31:0] v, input logic b);
    logic [7:0] digs[$];
    longint unsigned x;
    x = v;
    if (!b) begin
      do begin
        digs.push_front(8'h30 + 8'(x % 10));
        x = x / 10;
      end while (x != 0);
      foreach (digs[i]) exp_q.push_back(digs[i]);
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic accept(input logic [31:0] v, input logic b, output int to);
    int n;
    n = 0;
    to = 0;
    in_valid = 1'b1;
    in_value = v;
    in_blank = b;
    while (!in_ready) begin
      step();
      n++;
      if (n > 300) begin
        to = 1;
        break;
      end
    end
    step();
    in_valid = 1'b0;
    in_value = $urandom;
    in_blank = 1'($urandom_range(0, 1));
  endtask

  // Drains one line; cycle 1 is the cycle after the accept edge.
  task automatic collect(input int mode, output int first_cyc, output int last_cyc,
                         output int stall_err, output int rdy_err, output int to);
    int cyc;
    logic held;
    logic done;
    logic [7:0] hb;
    cyc = 1; held = 1'b0; done = 1'b0; hb = 8'h00;
    first_cyc = -1; last_cyc = -1; stall_err = 0; rdy_err = 0; to = 0;
    while (!done) begin
      if (cyc > 300) begin
        to = 1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_value = $urandom;
      in_blank = 1'($urandom_range(0, 1));
      if (in_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held && out_byte !== hb) stall_err++;
        if (out_ready) begin
          act_q.push_back(out_byte);
          held = 1'b0;
          if (out_byte == 8'h0A) begin
            done = 1'b1;
            last_cyc = cyc;
          end
        end else begin
          held = 1'b1;
          hb = out_byte;
        end
      end else if (held) begin
        stall_err++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = 0;
    n_checks++;
    if (act_q.size() !== exp_q.size())
      $display("FAIL %s_len: got %0d bytes, want %0d", name, act_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) if (i >= act_q.size() || act_q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL %s_bytes: %0d wrong bytes, got first %h want %h", name, bad,
                           (act_q.size() > 0) ? act_q[0] : 8'hxx, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_blank = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({in_ready, out_valid, out_byte, busy} !== {1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL reset_outputs: got rdy=%b vld=%b byte=%h busy=%b, want 1 0 00 0",
               in_ready, out_valid, out_byte, busy);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) step();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL post_reset_idle: got rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_6000();
    int ta, tc, f, l, se, re;
    act_q.delete(); exp_q.delete();
    accept(32'd6000, 1'b0, ta);
    collect(0, f, l, se, re, tc);
    model_line(32'd6000, 1'b0);
    n_checks++;
    if (ta + tc != 0) $display("FAIL v6000_timeout: got %0d, want 0", ta + tc); else n_pass++;
    n_checks++;
    if (f != 34) $display("FAIL v6000_latency: got %0d, want 34", f); else n_pass++;
    n_checks++;
    if (l - f != 4) $display("FAIL v6000_span: got %0d, want 4", l - f); else n_pass++;
    compare_stream("v6000");
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL v6000_ready_after_nl: got %b, want 1", in_ready); else n_pass++;
    n_checks++;
    if (re != 0) $display("FAIL v6000_rdy_busy: got %0d bad cycles, want 0", re); else n_pass++;
  endtask

  task automatic test_zero_blank_seven();
    int ta, tc, f, l, se, re, tot_to, tot_re;
    logic [31:0] vals[3];
    logic        blks[3];
    vals = '{32'd0, 32'd999, 32'd7};
    blks = '{1'b0, 1'b1, 1'b0};
    act_q.delete(); exp_q.delete();
    tot_to = 0; tot_re = 0;
    for (int i = 0; i < 3; i++) begin
      accept(vals[i], blks[i], ta);
      collect(0, f, l, se, re, tc);
      tot_to += ta + tc;
      tot_re += re;
      model_line(vals[i], blks[i]);
    end
    n_checks++;
    if (tot_to != 0) $display("FAIL zbs_timeout: got %0d, want 0", tot_to); else n_pass++;
    compare_stream("zero_blank_seven");
    n_checks++;
    if (tot_re != 0) $display("FAIL zbs_ready_low: got %0d bad cycles, want 0", tot_re); else n_pass++;
  endtask

  task automatic test_max_stall();
    int ta, tc, f, l, se, re;
    act_q.delete(); exp_q.delete();
    accept(32'hFFFF_FFFF, 1'b0, ta);
    collect(1, f, l, se, re, tc);
    model_line(32'hFFFF_FFFF, 1'b0);
    n_checks++;
    if (ta + tc != 0) $display("FAIL max_timeout: got %0d, want 0", ta + tc); else n_pass++;
    compare_stream("max_stall");
    n_checks++;
    if (se != 0) $display("FAIL max_stall_hold: got %0d unstable cycles, want 0", se); else n_pass++;
    n_checks++;
    if (f != 34) $display("FAIL max_latency: got %0d, want 34", f); else n_pass++;
  endtask

  task automatic test_blank_ignores_value();
    int ta, tc, f, l, se, re;
    act_q.delete(); exp_q.delete();
    accept(32'd123, 1'b1, ta);
    collect(0, f, l, se, re, tc);
    model_line(32'd123, 1'b1);
    n_checks++;
    if (ta + tc != 0) $display("FAIL blank_timeout: got %0d, want 0", ta + tc); else n_pass++;
    n_checks++;
    if (f != 1) $display("FAIL blank_latency: got %0d, want 1", f); else n_pass++;
    compare_stream("blank123");
  endtask

  task automatic test_back_to_back();
    int ta, tc, f, l, se, re, tot_to, tot_se, tot_rdy, bad;
    logic [31:0] vals[14];
    logic        blks[14];
    longint unsigned acc;
    logic any;
    logic [31:0] pv[$];
    logic        pb[$];
    vals = '{1000, 2000, 3000, 0, 4000, 0, 5000, 6000, 0, 7000, 8000, 9000, 0, 10000};
    blks = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0};
    act_q.delete(); exp_q.delete();
    tot_to = 0; tot_se = 0; tot_rdy = 0;
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 2)) step();
      accept(vals[i], blks[i], ta);
      collect(2, f, l, se, re, tc);
      tot_to += ta + tc;
      tot_se += se + re;
      if (in_ready !== 1'b1) tot_rdy++;
    end
    acc = 0; any = 1'b0;
    foreach (act_q[i]) begin
      if (act_q[i] == 8'h0A) begin
        pv.push_back(32'(acc));
        pb.push_back(!any);
        acc = 0; any = 1'b0;
      end else begin
        acc = acc * 10 + longint'(act_q[i] - 8'h30);
        any = 1'b1;
      end
    end
    n_checks++;
    if (tot_to != 0) $display("FAIL stream_timeout: got %0d, want 0", tot_to); else n_pass++;
    n_checks++;
    if (pv.size() != 14) $display("FAIL stream_lines: got %0d lines, want 14", pv.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (i >= pv.size()) bad++;
      else if (pb[i] !== blks[i] || (!blks[i] && pv[i] !== vals[i])) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL stream_records: got %0d wrong records, want 0", bad); else n_pass++;
    n_checks++;
    if (tot_se != 0) $display("FAIL stream_handshake: got %0d bad cycles, want 0", tot_se); else n_pass++;
    n_checks++;
    if (tot_rdy != 0) $display("FAIL stream_ready_after_nl: got %0d misses, want 0", tot_rdy); else n_pass++;
  endtask

  task automatic test_reset_mid_record();
    int ta, tc, f, l, se, re, n;
    act_q.delete(); exp_q.delete();
    accept(32'd6000, 1'b0, ta);
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'h30)
      $display("FAIL mid_second_digit: got vld=%b byte=%h, want 1 30", out_valid, out_byte);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_byte, busy} !== {1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL mid_async_reset: got rdy=%b vld=%b byte=%h busy=%b, want 1 0 00 0",
               in_ready, out_valid, out_byte, busy);
    else n_pass++;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL mid_no_leftover: got vld=%b, want 0", out_valid); else n_pass++;
    accept(32'd42, 1'b0, ta);
    collect(0, f, l, se, re, tc);
    model_line(32'd42, 1'b0);
    n_checks++;
    if (ta + tc != 0) $display("FAIL mid_timeout: got %0d, want 0", ta + tc); else n_pass++;
    compare_stream("after_reset_42");
  endtask

  initial begin
    test_reset();
    test_6000();
    test_zero_blank_seven();
    test_max_stall();
    test_blank_ignores_value();
    test_back_to_back();
    test_reset_mid_record();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
